// File: rtl/prt_pkg.sv
// Shared types and default sizing for the packet reference table.
// Sub-modules and the bench import this package.
package prt_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_SLOTS  = 4;
    localparam int DEF_SLOT_DEPTH = 2048;
    localparam int DEF_SW         = $clog2(DEF_NUM_SLOTS);
    localparam int DEF_LW         = $clog2(DEF_SLOT_DEPTH) + 1;

    typedef enum logic {
        W_IDLE,
        W_ACTIVE
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_ACTIVE
    } rstate_e;

    typedef logic [DEF_SW-1:0] slot_idx_t;
    typedef logic [DEF_LW-1:0] len_t;

endpackage

// File: rtl/prt_slot_mem.sv
// Packet storage: one synchronous write port and one asynchronous read port,
// addressed as {slot, beat pointer}. Contents are never reset.
module prt_slot_mem #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_SLOTS  = 4,
    parameter  int SLOT_DEPTH = 2048,
    localparam int AW         = $clog2(NUM_SLOTS * SLOT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS*SLOT_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/packet_reference_table.sv
// Slot-based packet buffer behind the dealer's PRT methods: allocate, stream in,
// commit, stream out and invalidate slots, all with EN/RDY handshakes.
module packet_reference_table
    import prt_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter  int SLOT_DEPTH = DEF_SLOT_DEPTH,
    localparam int SW         = $clog2(NUM_SLOTS),
    localparam int LW         = $clog2(SLOT_DEPTH) + 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  EN_start_writing_prt_entry,
    output logic                  RDY_start_writing_prt_entry,
    output logic [SW-1:0]         start_writing_prt_entry,

    input  logic                  EN_write_prt_entry,
    output logic                  RDY_write_prt_entry,
    input  logic [DATA_WIDTH-1:0] write_prt_entry_data,

    input  logic                  EN_finish_writing_prt_entry,
    output logic                  RDY_finish_writing_prt_entry,

    input  logic                  EN_invalidate_prt_entry,
    output logic                  RDY_invalidate_prt_entry,
    input  logic [SW-1:0]         invalidate_prt_entry_slot,

    input  logic                  EN_start_reading_prt_entry,
    output logic                  RDY_start_reading_prt_entry,
    input  logic [SW-1:0]         start_reading_prt_entry_slot,

    input  logic                  EN_read_prt_entry,
    output logic                  RDY_read_prt_entry,
    output logic [DATA_WIDTH:0]   read_prt_entry,

    output logic                  is_prt_slot_free,
    output logic                  RDY_is_prt_slot_free
);

    logic [NUM_SLOTS-1:0] valid_q;
    logic [LW-1:0]        len_q [NUM_SLOTS];

    wstate_e              wstate_q;
    logic [SW-1:0]        wslot_q;
    logic [LW-1:0]        wptr_q;

    rstate_e              rstate_q;
    logic [SW-1:0]        rslot_q;
    logic [LW-1:0]        rptr_q;
    logic [LW-1:0]        rlen_q;
    logic                 rok_q;

    logic [NUM_SLOTS-1:0] allocatable;
    logic [SW-1:0]        alloc_slot;
    logic                 any_free;

    logic                 start_wr_fire;
    logic                 wr_fire;
    logic                 fin_fire;
    logic                 inv_fire;
    logic                 rd_start_fire;
    logic                 rd_fire;
    logic                 rd_last;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // A slot is free only when it holds no packet and neither transfer owns it;
    // the downward scan leaves the lowest free index in alloc_slot.
    always_comb begin
        allocatable = '0;
        alloc_slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            allocatable[i] = !valid_q[i]
                          && !(wstate_q == W_ACTIVE && wslot_q == SW'(i))
                          && !(rstate_q == R_ACTIVE && rslot_q == SW'(i));
            if (allocatable[i]) begin
                alloc_slot = SW'(i);
            end
        end
    end

    assign any_free = |allocatable;

    assign RDY_start_writing_prt_entry  = any_free && (wstate_q == W_IDLE);
    assign start_writing_prt_entry      = alloc_slot;
    assign RDY_write_prt_entry          = (wstate_q == W_ACTIVE) && (wptr_q != LW'(SLOT_DEPTH));
    assign RDY_finish_writing_prt_entry = (wstate_q == W_ACTIVE) && (wptr_q != '0);
    assign RDY_invalidate_prt_entry     = 1'b1;
    assign RDY_start_reading_prt_entry  = (rstate_q == R_IDLE);
    assign RDY_read_prt_entry           = (rstate_q == R_ACTIVE);
    assign is_prt_slot_free             = any_free;
    assign RDY_is_prt_slot_free         = 1'b1;

    assign start_wr_fire = EN_start_writing_prt_entry  && RDY_start_writing_prt_entry;
    assign wr_fire       = EN_write_prt_entry          && RDY_write_prt_entry;
    assign fin_fire      = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
    assign inv_fire      = EN_invalidate_prt_entry     && RDY_invalidate_prt_entry;
    assign rd_start_fire = EN_start_reading_prt_entry  && RDY_start_reading_prt_entry;
    assign rd_fire       = EN_read_prt_entry           && RDY_read_prt_entry;

    // An invalid slot yields a single error beat, so it is always "last".
    assign rd_last = !rok_q || (rptr_q == (rlen_q - LW'(1)));

    always_comb begin
        read_prt_entry = '0;
        if (rstate_q == R_ACTIVE) begin
            read_prt_entry = {rd_last, (rok_q ? mem_rdata : {DATA_WIDTH{1'b0}})};
        end
    end

    prt_slot_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_DEPTH (SLOT_DEPTH)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_fire),
        .wr_addr ({wslot_q, wptr_q[LW-2:0]}),
        .wr_data (write_prt_entry_data),
        .rd_addr ({rslot_q, rptr_q[LW-2:0]}),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wstate_q <= W_IDLE;
            wslot_q  <= '0;
            wptr_q   <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (start_wr_fire) begin
                        wslot_q  <= alloc_slot;
                        wptr_q   <= '0;
                        wstate_q <= W_ACTIVE;
                    end
                end
                W_ACTIVE: begin
                    if (fin_fire) begin
                        wstate_q <= W_IDLE;
                    end else if (wr_fire) begin
                        wptr_q <= wptr_q + LW'(1);
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Finish is applied after invalidate so a commit always wins on its own slot;
    // invalidate of the open write slot is ignored outright.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            if (inv_fire && !(wstate_q == W_ACTIVE && wslot_q == invalidate_prt_entry_slot)) begin
                valid_q[invalidate_prt_entry_slot] <= 1'b0;
            end
            if (fin_fire) begin
                valid_q[wslot_q] <= 1'b1;
                len_q[wslot_q]   <= wptr_q;
            end
        end
    end

    // Validity and length are captured at start so an invalidate of the slot
    // being read cannot truncate or corrupt the packet in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rstate_q <= R_IDLE;
            rslot_q  <= '0;
            rptr_q   <= '0;
            rlen_q   <= '0;
            rok_q    <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (rd_start_fire) begin
                        rslot_q  <= start_reading_prt_entry_slot;
                        rptr_q   <= '0;
                        rok_q    <= valid_q[start_reading_prt_entry_slot];
                        rlen_q   <= len_q[start_reading_prt_entry_slot];
                        rstate_q <= R_ACTIVE;
                    end
                end
                R_ACTIVE: begin
                    if (rd_fire) begin
                        if (rd_last) begin
                            rstate_q <= R_IDLE;
                        end else begin
                            rptr_q <= rptr_q + LW'(1);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_reference_table.sv
// Self-checking bench: a queue-based model of slot contents and transfers is
// compared against every DUT output each cycle, plus literal spot checks.
module tb_packet_reference_table;
    import prt_pkg::*;

    localparam int DW    = DEF_DATA_WIDTH;
    localparam int NS    = DEF_NUM_SLOTS;
    localparam int DEPTH = DEF_SLOT_DEPTH;

    logic            clk = 1'b0;
    logic            RST_N;
    logic            EN_start_writing_prt_entry;
    logic            RDY_start_writing_prt_entry;
    slot_idx_t       start_writing_prt_entry;
    logic            EN_write_prt_entry;
    logic            RDY_write_prt_entry;
    logic [DW-1:0]   write_prt_entry_data;
    logic            EN_finish_writing_prt_entry;
    logic            RDY_finish_writing_prt_entry;
    logic            EN_invalidate_prt_entry;
    logic            RDY_invalidate_prt_entry;
    slot_idx_t       invalidate_prt_entry_slot;
    logic            EN_start_reading_prt_entry;
    logic            RDY_start_reading_prt_entry;
    slot_idx_t       start_reading_prt_entry_slot;
    logic            EN_read_prt_entry;
    logic            RDY_read_prt_entry;
    logic [DW:0]     read_prt_entry;
    logic            is_prt_slot_free;
    logic            RDY_is_prt_slot_free;

    int pass_count  = 0;
    int check_count = 0;
    bit check_en    = 1'b0;

    // Behavioural model state
    bit          m_valid [NS];
    int          m_len   [NS];
    logic [7:0]  m_mem   [NS][DEPTH];
    bit          m_wopen;
    int          m_wslot;
    int          m_wcnt;
    logic [7:0]  m_wbuf  [DEPTH];
    bit          m_ropen;
    int          m_rslot;
    logic [8:0]  m_rq    [$];

    always #5 clk = ~clk;

    packet_reference_table dut (
        .CLK                          (clk),
        .RST_N                        (RST_N),
        .EN_start_writing_prt_entry   (EN_start_writing_prt_entry),
        .RDY_start_writing_prt_entry  (RDY_start_writing_prt_entry),
        .start_writing_prt_entry      (start_writing_prt_entry),
        .EN_write_prt_entry           (EN_write_prt_entry),
        .RDY_write_prt_entry          (RDY_write_prt_entry),
        .write_prt_entry_data         (write_prt_entry_data),
        .EN_finish_writing_prt_entry  (EN_finish_writing_prt_entry),
        .RDY_finish_writing_prt_entry (RDY_finish_writing_prt_entry),
        .EN_invalidate_prt_entry      (EN_invalidate_prt_entry),
        .RDY_invalidate_prt_entry     (RDY_invalidate_prt_entry),
        .invalidate_prt_entry_slot    (invalidate_prt_entry_slot),
        .EN_start_reading_prt_entry   (EN_start_reading_prt_entry),
        .RDY_start_reading_prt_entry  (RDY_start_reading_prt_entry),
        .start_reading_prt_entry_slot (start_reading_prt_entry_slot),
        .EN_read_prt_entry            (EN_read_prt_entry),
        .RDY_read_prt_entry           (RDY_read_prt_entry),
        .read_prt_entry               (read_prt_entry),
        .is_prt_slot_free             (is_prt_slot_free),
        .RDY_is_prt_slot_free         (RDY_is_prt_slot_free)
    );

    task automatic check_output(input string name, input logic [8:0] actual, input logic [8:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    function automatic int exp_alloc();
        for (int i = 0; i < NS; i++) begin
            if (!m_valid[i] && !(m_wopen && m_wslot == i) && !(m_ropen && m_rslot == i)) begin
                return i;
            end
        end
        return -1;
    endfunction

    task automatic model_step();
        int  a;
        int  s;
        bit  f_sw, f_w, f_f, f_sr, f_r;
        if (!RST_N) begin
            for (int i = 0; i < NS; i++) begin
                m_valid[i] = 1'b0;
                m_len[i]   = 0;
            end
            m_wopen = 1'b0;
            m_wcnt  = 0;
            m_ropen = 1'b0;
            m_rq.delete();
            return;
        end
        a    = exp_alloc();
        f_sw = EN_start_writing_prt_entry  && (a >= 0) && !m_wopen;
        f_w  = EN_write_prt_entry          && m_wopen && (m_wcnt < DEPTH);
        f_f  = EN_finish_writing_prt_entry && m_wopen && (m_wcnt > 0);
        f_sr = EN_start_reading_prt_entry  && !m_ropen;
        f_r  = EN_read_prt_entry           && m_ropen;
        if (f_r) begin
            void'(m_rq.pop_front());
            if (m_rq.size() == 0) m_ropen = 1'b0;
        end
        if (f_sr) begin
            s       = int'(start_reading_prt_entry_slot);
            m_rslot = s;
            m_ropen = 1'b1;
            if (m_valid[s]) begin
                for (int i = 0; i < m_len[s]; i++) begin
                    m_rq.push_back({(i == m_len[s] - 1), m_mem[s][i]});
                end
            end else begin
                m_rq.push_back(9'h100);
            end
        end
        if (EN_invalidate_prt_entry) begin
            s = int'(invalidate_prt_entry_slot);
            if (!(m_wopen && m_wslot == s)) m_valid[s] = 1'b0;
        end
        if (f_f) begin
            for (int i = 0; i < m_wcnt; i++) m_mem[m_wslot][i] = m_wbuf[i];
            m_len[m_wslot]   = m_wcnt;
            m_valid[m_wslot] = 1'b1;
            m_wopen          = 1'b0;
        end else if (f_w) begin
            m_wbuf[m_wcnt] = write_prt_entry_data;
            m_wcnt++;
        end
        if (f_sw) begin
            m_wopen = 1'b1;
            m_wslot = a;
            m_wcnt  = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (check_en) begin
            int a;
            a = exp_alloc();
            check_output("rdy_start_wr", RDY_start_writing_prt_entry, (a >= 0) && !m_wopen);
            check_output("start_wr_slot", start_writing_prt_entry, (a >= 0) ? a : 0);
            check_output("rdy_write", RDY_write_prt_entry, m_wopen && (m_wcnt < DEPTH));
            check_output("rdy_finish", RDY_finish_writing_prt_entry, m_wopen && (m_wcnt > 0));
            check_output("rdy_inval", RDY_invalidate_prt_entry, 1'b1);
            check_output("rdy_start_rd", RDY_start_reading_prt_entry, !m_ropen);
            check_output("rdy_read", RDY_read_prt_entry, m_ropen);
            check_output("read_beat", read_prt_entry, m_ropen ? m_rq[0] : 9'h000);
            check_output("slot_free", is_prt_slot_free, a >= 0);
            check_output("rdy_slot_free", RDY_is_prt_slot_free, 1'b1);
        end
    end

    task automatic clear_ens();
        EN_start_writing_prt_entry  = 1'b0;
        EN_write_prt_entry          = 1'b0;
        EN_finish_writing_prt_entry = 1'b0;
        EN_invalidate_prt_entry     = 1'b0;
        EN_start_reading_prt_entry  = 1'b0;
        EN_read_prt_entry           = 1'b0;
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        @(negedge clk);
        clear_ens();
    endtask

    task automatic write_packet(input int n, input logic [7:0] base);
        EN_start_writing_prt_entry = 1'b1;
        apply_stimulus();
        for (int k = 0; k < n; k++) begin
            EN_write_prt_entry   = 1'b1;
            write_prt_entry_data = base + 8'(k);
            apply_stimulus();
        end
        EN_finish_writing_prt_entry = 1'b1;
        apply_stimulus();
    endtask

    task automatic invalidate(input int s);
        EN_invalidate_prt_entry   = 1'b1;
        invalidate_prt_entry_slot = slot_idx_t'(s);
        apply_stimulus();
    endtask

    task automatic start_read(input int s);
        EN_start_reading_prt_entry   = 1'b1;
        start_reading_prt_entry_slot = slot_idx_t'(s);
        apply_stimulus();
    endtask

    initial begin
        clear_ens();
        write_prt_entry_data         = '0;
        invalidate_prt_entry_slot    = '0;
        start_reading_prt_entry_slot = '0;
        RST_N = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RST_N    = 1'b1;
        check_en = 1'b1;

        $display("[TB] three-beat packet round trip");
        check_output("lit_reset_slot", start_writing_prt_entry, 0);
        write_packet(3, 8'hA1);
        start_read(0);
        check_output("lit_beat0", read_prt_entry, 9'h0A1);
        EN_read_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_beat1", read_prt_entry, 9'h0A2);
        EN_read_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_beat2", read_prt_entry, 9'h1A3);
        EN_read_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_read_done", RDY_read_prt_entry, 0);

        $display("[TB] fill all slots and free slot 2");
        invalidate(0);
        for (int s = 0; s < NS; s++) begin
            check_output("lit_alloc_order", start_writing_prt_entry, s);
            write_packet(1, 8'(8'h30 + s));
        end
        check_output("lit_full_free", is_prt_slot_free, 0);
        check_output("lit_full_rdy", RDY_start_writing_prt_entry, 0);
        invalidate(2);
        check_output("lit_realloc2", start_writing_prt_entry, 2);

        $display("[TB] full-depth packet");
        invalidate(0);
        invalidate(1);
        invalidate(3);
        check_output("lit_depth_slot", start_writing_prt_entry, 0);
        EN_start_writing_prt_entry = 1'b1; apply_stimulus();
        for (int k = 0; k < DEPTH; k++) begin
            EN_write_prt_entry   = 1'b1;
            write_prt_entry_data = 8'($urandom);
            apply_stimulus();
        end
        check_output("lit_wr_full", RDY_write_prt_entry, 0);
        check_output("lit_fin_rdy", RDY_finish_writing_prt_entry, 1);
        EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'hEE; apply_stimulus();
        EN_finish_writing_prt_entry = 1'b1; apply_stimulus();
        start_read(0);
        for (int k = 0; k < DEPTH - 1; k++) begin
            EN_read_prt_entry = 1'b1; apply_stimulus();
        end
        check_output("lit_depth_last", read_prt_entry[8], 1);
        EN_read_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_depth_done", RDY_read_prt_entry, 0);

        $display("[TB] read of an invalid slot");
        start_read(1);
        check_output("lit_err_beat", read_prt_entry, 9'h100);
        EN_read_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_err_idle", RDY_start_reading_prt_entry, 1);

        $display("[TB] invalidate during read");
        invalidate(0);
        write_packet(3, 8'h10);
        write_packet(2, 8'h20);
        write_packet(2, 8'h40);
        write_packet(2, 8'h50);
        check_output("lit_all_full", is_prt_slot_free, 0);
        start_read(0);
        check_output("lit_inv_b0", read_prt_entry, 9'h010);
        EN_read_prt_entry         = 1'b1;
        EN_invalidate_prt_entry   = 1'b1;
        invalidate_prt_entry_slot = 0;
        apply_stimulus();
        check_output("lit_inv_b1", read_prt_entry, 9'h011);
        check_output("lit_inv_held", is_prt_slot_free, 0);
        EN_read_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_inv_b2", read_prt_entry, 9'h112);
        check_output("lit_inv_held2", is_prt_slot_free, 0);
        EN_read_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_inv_freed", is_prt_slot_free, 1);
        check_output("lit_inv_slot", start_writing_prt_entry, 0);

        $display("[TB] reset mid-write");
        EN_start_writing_prt_entry = 1'b1; apply_stimulus();
        EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'h77; apply_stimulus();
        EN_write_prt_entry = 1'b1; write_prt_entry_data = 8'h78; apply_stimulus();
        RST_N = 1'b0; apply_stimulus();
        RST_N = 1'b1;
        check_output("lit_rst_rdy_sw", RDY_start_writing_prt_entry, 1);
        check_output("lit_rst_slot", start_writing_prt_entry, 0);
        check_output("lit_rst_rdy_w", RDY_write_prt_entry, 0);
        check_output("lit_rst_rdy_f", RDY_finish_writing_prt_entry, 0);
        check_output("lit_rst_rdy_r", RDY_read_prt_entry, 0);
        check_output("lit_rst_data", read_prt_entry, 0);
        check_output("lit_rst_free", is_prt_slot_free, 1);
        EN_start_writing_prt_entry = 1'b1; apply_stimulus();
        check_output("lit_wr_latency", RDY_write_prt_entry, 1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            EN_start_writing_prt_entry   = ($urandom_range(0, 3) == 0);
            EN_finish_writing_prt_entry  = ($urandom_range(0, 9) == 0);
            EN_write_prt_entry           = !EN_finish_writing_prt_entry && ($urandom_range(0, 1) == 1);
            write_prt_entry_data         = 8'($urandom);
            EN_invalidate_prt_entry      = ($urandom_range(0, 5) == 0);
            invalidate_prt_entry_slot    = slot_idx_t'($urandom_range(0, NS - 1));
            EN_start_reading_prt_entry   = ($urandom_range(0, 3) == 0);
            start_reading_prt_entry_slot = slot_idx_t'($urandom_range(0, NS - 1));
            EN_read_prt_entry            = ($urandom_range(0, 1) == 1);
            RST_N                        = ($urandom_range(0, 799) != 0);
            apply_stimulus();
        end
        RST_N = 1'b1;
        apply_stimulus();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/packet_reference_table.md
# packet_reference_table

Slot-based packet buffer that serves the master packet dealer's PRT method interface: the dealer allocates a free slot, streams a packet into it byte by byte, commits it, later streams it back out and invalidates the slot. Sits directly downstream of the dealer as the storage behind every `*_prt_entry` method; all methods follow EN/RDY semantics, where an action fires on a cycle in which both EN and RDY are high.

## Interface
- DATA_WIDTH, 8, bits per stored beat
- NUM_SLOTS, 4, number of packet slots
- SLOT_DEPTH, 2048, maximum beats per slot
- Derived: SW = $clog2(NUM_SLOTS); LW = $clog2(SLOT_DEPTH)+1

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- EN_start_writing_prt_entry  in  1  allocate a slot and open a write
- RDY_start_writing_prt_entry  out  1  a slot is allocatable and no write is open
- start_writing_prt_entry  out  SW  slot that will be allocated; valid while RDY high
- EN_write_prt_entry  in  1  write one beat
- RDY_write_prt_entry  out  1  write is open and the slot is not full
- write_prt_entry_data  in  DATA_WIDTH  beat to store
- EN_finish_writing_prt_entry  in  1  commit the open write
- RDY_finish_writing_prt_entry  out  1  write is open with at least 1 beat
- EN_invalidate_prt_entry  in  1  free a slot
- RDY_invalidate_prt_entry  out  1  constant 1 after reset
- invalidate_prt_entry_slot  in  SW  slot to free
- EN_start_reading_prt_entry  in  1  open a read
- RDY_start_reading_prt_entry  out  1  no read is open
- start_reading_prt_entry_slot  in  SW  slot to read
- EN_read_prt_entry  in  1  consume one read beat
- RDY_read_prt_entry  out  1  read is open
- read_prt_entry  out  DATA_WIDTH+1  {last, data}; valid while RDY_read high, 0 otherwise
- is_prt_slot_free  out  1  at least one slot is allocatable
- RDY_is_prt_slot_free  out  1  constant 1 after reset

## Operation
- Per-slot state: valid bit and LW-bit length. A slot is allocatable iff it is not valid, not the open write slot, and not the open read slot.
- Allocation: start_writing_prt_entry = lowest-index allocatable slot.
- Write FSM (W_IDLE, W_ACTIVE):
  - Start: latch wslot, wptr=0, go to W_ACTIVE.
  - Write: mem[wslot][wptr]=data, wptr++. RDY is low when wptr==SLOT_DEPTH.
  - Finish: len[wslot]=wptr, valid[wslot]=1, go to W_IDLE.
- Read FSM (R_IDLE, R_ACTIVE):
  - Start: latch rslot, rptr=0, go to R_ACTIVE.
  - Output: if valid[rslot], read_prt_entry = {rptr==len-1, mem[rslot][rptr]}, combinational from the async memory read. If the slot is invalid, a single beat {1, 0} is presented.
  - Read: rptr++; the last beat returns the FSM to R_IDLE.
  - Reading does not clear valid.
- Invalidate: clears valid[slot]. It has no effect on an invalid slot or on the open write slot. It may target the open read slot: the read completes with the original data, and the slot becomes allocatable only after the read ends.
- Write and read FSMs run concurrently. They never address the same slot, because a read of a non-valid slot returns only the error beat.

## Timing
- Reset, all synchronous:
  - valid=0, len=0, both FSMs idle, pointers 0.
  - Outputs after reset: RDY_start_writing=1, start_writing_prt_entry=0, RDY_write=0, RDY_finish=0, RDY_invalidate=1, RDY_start_reading=1, RDY_read=0, read_prt_entry=0, is_prt_slot_free=1, RDY_is_prt_slot_free=1.
  - Memory contents are not reset. Reset mid-write or mid-read abandons the transfer and frees every slot.
- All RDY and data outputs are combinational from registered state only, never from EN inputs.
- Latency:
  - Start → first write or read RDY: 1 cycle.
  - Committed slot readable: the cycle after finish.
  - Invalidated slot allocatable: the cycle after invalidate.
- Throughput: 1 beat/cycle on each of write and read.
- Same cycle, different slots: finish, invalidate and start_reading all take effect. Start_reading in the same cycle as finish of that slot sees the pre-finish valid=0 and returns the error beat.

## Structure
- Package prt_pkg: wstate_e/rstate_e enums, slot_idx_t, len_t.
- Sub-module prt_slot_mem: NUM_SLOTS*SLOT_DEPTH × DATA_WIDTH; one sync write port, one async read port, addressed {slot, ptr}.

## Test plan
- Reset, write 3 beats 0xA1,0xA2,0xA3 → allocated slot 0; start_reading slot 0 yields {0,A1},{0,A2},{1,A3}, then RDY_read=0.
- Commit 4 one-beat packets → slots 0..3 allocated in order, is_prt_slot_free=0, RDY_start_writing=0. Invalidate slot 2 → next cycle start_writing_prt_entry=2.
- Write SLOT_DEPTH beats → RDY_write drops after beat SLOT_DEPTH; finish commits len=SLOT_DEPTH; the last beat read has MSB=1.
- Start_reading an invalid slot 1 → one beat {1,0x00}, read FSM idle next cycle.
- Invalidate slot 0 mid-read of slot 0, with all other slots full → read data intact; slot 0 not offered until the cycle after the last beat.
- RST_N low mid-write (2 beats in) → all RDYs return to their reset values; a new write is allocated slot 0.
